// File: rtl/temp_report_pkg.sv
// Shared constants for the temperature report scheduler.
// TEMP_REPORT_FRAC_EN adds the '.' and tenths digit to each report line.
package temp_report_pkg;

  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] CMD_STOP  = 8'h53;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_REP   = 8'h52;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SNAP = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

`ifdef TEMP_REPORT_FRAC_EN
  localparam logic [3:0] LINE_LEN = 4'd11;
`else
  localparam logic [3:0] LINE_LEN = 4'd9;
`endif

  typedef struct packed {
    logic       neg;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] unit;
    logic [3:0] tenth;
  } fmt_t;

endpackage

// File: rtl/temp_fmt.sv
// Combinational raw (1/16 degC) to sign + BCD digits converter.
// TEMP_REPORT_FRAC_EN makes the tenths digit count towards the non-zero sign test.
module temp_fmt
  import temp_report_pkg::*;
(
  input  logic [15:0] raw,
  output fmt_t        fmt
);

  logic [15:0] mag;
  logic [11:0] whole;
  logic [7:0]  int_sat;
  logic [7:0]  frac_prod;
  logic [7:0]  rem;
  logic [7:0]  tens_w;
  logic [7:0]  units_w;
  logic        hun_bit;
  logic        nonzero;

  always_comb begin
    // -32768 negates to itself, which still reads correctly as unsigned 32768
    mag       = raw[15] ? (~raw + 16'd1) : raw;
    whole     = mag[15:4];
    int_sat   = (whole > 12'd199) ? 8'd199 : whole[7:0];
    frac_prod = {4'd0, mag[3:0]} * 8'd10;
    hun_bit   = (int_sat >= 8'd100);
    rem       = hun_bit ? (int_sat - 8'd100) : int_sat;
    tens_w    = rem / 8'd10;
    units_w   = rem % 8'd10;
`ifdef TEMP_REPORT_FRAC_EN
    nonzero   = (int_sat != 8'd0) || (frac_prod[7:4] != 4'd0);
`else
    nonzero   = (int_sat != 8'd0);
`endif
    fmt.neg   = raw[15] && nonzero;
    fmt.hun   = {3'd0, hun_bit};
    fmt.ten   = tens_w[3:0];
    fmt.unit  = units_w[3:0];
    fmt.tenth = frac_prod[7:4];
  end

endmodule

// File: rtl/temp_report_scheduler.sv
// Periodic multi-channel temperature reporter: snapshots readings, streams ASCII lines, drives alarms.
// Build option TEMP_REPORT_FRAC_EN selects 11-byte lines with tenths; otherwise 9-byte lines.
module temp_report_scheduler
  import temp_report_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int PERIOD_MS = 1500,
  parameter int NUM_CH    = 1,
  parameter int ALARM_HI  = 30,
  parameter int ALARM_LO  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*NUM_CH-1:0]  t_data,
  input  logic [7:0]            cmd_data,
  input  logic                  cmd_vld,
  output logic [7:0]            tx_data,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic [NUM_CH-1:0]     alarm,
  output logic                  busy
);

  localparam int          PERIOD_CYC = PERIOD_MS * (CLK_FREQ / 1000);
  localparam logic [31:0] CNT_LAST   = 32'(PERIOD_CYC - 1);
  localparam logic [2:0]  CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [3:0]  BYTE_LAST  = LINE_LEN - 4'd1;
  localparam logic signed [11:0] HI_DEG = 12'(ALARM_HI);
  localparam logic signed [11:0] LO_DEG = 12'(ALARM_LO);

  logic                 run_reg;
  logic [31:0]          cnt_reg;
  logic                 pending_reg;
  logic [1:0]           state_reg;
  logic [3:0]           byte_reg;
  logic [2:0]           ch_reg;
  logic [16*NUM_CH-1:0] snap_reg;
  logic [NUM_CH-1:0]    alarm_reg;

  logic        cmd_stop;
  logic        cmd_go;
  logic        cmd_rep;
  logic        tick;
  logic        trigger;
  logic [15:0] cur_raw;
  fmt_t        cur_fmt;
  logic [7:0]  line_byte;
  logic [NUM_CH-1:0] alarm_set;
  logic [NUM_CH-1:0] alarm_clr;

  assign cmd_stop = cmd_vld && (cmd_data == CMD_STOP);
  assign cmd_go   = cmd_vld && (cmd_data == CMD_GO);
  assign cmd_rep  = cmd_vld && (cmd_data == CMD_REP);
  assign tick     = run_reg && (cnt_reg == CNT_LAST);
  assign trigger  = tick || cmd_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg <= 1'b1;
      cnt_reg <= 32'd0;
    end else if (cmd_stop) begin
      run_reg <= 1'b0;
      cnt_reg <= 32'd0;
    end else if (cmd_go) begin
      run_reg <= 1'b1;
      cnt_reg <= 32'd0;
    end else if (run_reg) begin
      cnt_reg <= tick ? 32'd0 : cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b0;
      byte_reg    <= 4'd0;
      ch_reg      <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A trigger arriving in the same cycle as a pending restart merges into it
          if (trigger || pending_reg) begin
            state_reg   <= ST_SNAP;
            pending_reg <= 1'b0;
          end
        end
        ST_SNAP: begin
          state_reg <= ST_SEND;
          byte_reg  <= 4'd0;
          ch_reg    <= 3'd0;
          if (trigger) pending_reg <= 1'b1;
        end
        ST_SEND: begin
          if (trigger) pending_reg <= 1'b1;
          if (tx_rdy) begin
            if (byte_reg == BYTE_LAST) begin
              byte_reg <= 4'd0;
              if (ch_reg == CH_LAST) state_reg <= ST_IDLE;
              else ch_reg <= ch_reg + 3'd1;
            end else begin
              byte_reg <= byte_reg + 4'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Alarm thresholds compare the whole-degree part (arithmetic >>> 4) of the live input
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_alarm
      logic signed [11:0] deg;
      assign deg           = $signed(t_data[16*gi+4 +: 12]);
      assign alarm_set[gi] = (deg >= HI_DEG);
      assign alarm_clr[gi] = (deg <= LO_DEG);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_reg  <= '0;
      alarm_reg <= '0;
    end else if (state_reg == ST_SNAP) begin
      snap_reg  <= t_data;
      alarm_reg <= (alarm_reg | alarm_set) & ~alarm_clr;
    end
  end

  assign cur_raw = snap_reg[16*ch_reg +: 16];

  temp_fmt u_fmt (
    .raw (cur_raw),
    .fmt (cur_fmt)
  );

  always_comb begin
    line_byte = 8'h00;
    case (byte_reg)
      4'd0: line_byte = ASC_T;
      4'd1: line_byte = ASC_ZERO + {5'd0, ch_reg};
      4'd2: line_byte = ASC_EQ;
      4'd3: line_byte = cur_fmt.neg ? ASC_MINUS : ASC_PLUS;
      4'd4: line_byte = ASC_ZERO + {4'd0, cur_fmt.hun};
      4'd5: line_byte = ASC_ZERO + {4'd0, cur_fmt.ten};
      4'd6: line_byte = ASC_ZERO + {4'd0, cur_fmt.unit};
`ifdef TEMP_REPORT_FRAC_EN
      4'd7: line_byte = ASC_DOT;
      4'd8: line_byte = ASC_ZERO + {4'd0, cur_fmt.tenth};
      4'd9: line_byte = ASC_CR;
      4'd10: line_byte = ASC_LF;
`else
      4'd7: line_byte = ASC_CR;
      4'd8: line_byte = ASC_LF;
`endif
      default: line_byte = 8'h00;
    endcase
  end

  assign tx_vld  = (state_reg == ST_SEND);
  assign tx_data = tx_vld ? line_byte : 8'h00;
  assign busy    = (state_reg != ST_IDLE);
  assign alarm   = alarm_reg;

endmodule

// File: tb/tb_temp_report_scheduler.sv
// Directed bench for temp_report_scheduler: two channels, 100-cycle report period.
// Expected lines follow the TEMP_REPORT_FRAC_EN build option.
module tb_temp_report_scheduler;

  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] t_data = 32'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_vld = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b1;
  logic [1:0]  alarm;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  temp_report_scheduler #(
    .CLK_FREQ  (10_000),
    .PERIOD_MS (10),
    .NUM_CH    (2),
    .ALARM_HI  (30),
    .ALARM_LO  (28)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_data   (t_data),
    .cmd_data (cmd_data),
    .cmd_vld  (cmd_vld),
    .tx_data  (tx_data),
    .tx_vld   (tx_vld),
    .tx_rdy   (tx_rdy),
    .alarm    (alarm),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_data = c;
    cmd_vld  = 1'b1;
    step();
    cmd_vld  = 1'b0;
    cmd_data = 8'h00;
  endtask

  function automatic string line(input string pre, input string frac);
`ifdef TEMP_REPORT_FRAC_EN
    return {pre, ".", frac, "\015\012"};
`else
    return {pre, "\015\012"};
`endif
  endfunction

  task automatic recv(input string tag, input string s, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int w;
      w = 0;
      while (!tx_vld && w < 60) begin
        step();
        w++;
      end
      chk($sformatf("%s_vld%0d", tag, i), 32'(tx_vld), 32'd1);
      chk($sformatf("%s_b%0d", tag, i), 32'(tx_data), 32'(s[i]));
      step();
    end
  endtask

  task automatic report(input string tag, input string s, input logic [1:0] exp_alarm);
    send_cmd(8'h52);
    chk({tag, "_snap_busy"}, 32'(busy), 32'd1);
    chk({tag, "_snap_vld"}, 32'(tx_vld), 32'd0);
    step();
    chk({tag, "_latency"}, 32'(tx_vld), 32'd1);
    chk({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm));
    recv(tag, s, 0, s.len() - 1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    $display("report %s: %0d bytes, alarm %b", tag, s.len(), alarm);
  endtask

  initial begin
    string f1, f2, fg;
    int n, cnt;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_vld",   32'(tx_vld),  32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    chk("rst_alarm", 32'(alarm),   32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    rst = 1'b0;
    send_cmd(8'h53);

    t_data = {16'hFF5E, 16'h0191};
    report("basic", {line("T0=+025", "0"), line("T1=-010", "1")}, 2'b00);
    t_data = {16'h01F0, 16'hFFFF};
    report("negzero", {line("T0=+000", "0"), line("T1=+031", "0")}, 2'b10);

    t_data = {16'h01F0, 16'h01E0};
    report("hyst30", {line("T0=+030", "0"), line("T1=+031", "0")}, 2'b11);
    t_data = {16'h01F0, 16'h01D0};
    report("hyst29a", {line("T0=+029", "0"), line("T1=+031", "0")}, 2'b11);
    t_data = {16'h01F0, 16'h01C0};
    report("hyst28", {line("T0=+028", "0"), line("T1=+031", "0")}, 2'b10);
    t_data = {16'h01F0, 16'h01D0};
    report("hyst29b", {line("T0=+029", "0"), line("T1=+031", "0")}, 2'b10);

    t_data = {16'h7FF0, 16'h8000};
    report("sat", {line("T0=-199", "0"), line("T1=+199", "0")}, 2'b10);
    t_data = {16'h0C35, 16'hFE70};
    report("hund", {line("T0=-025", "0"), line("T1=+195", "3")}, 2'b10);

    // Backpressure with two extra requests: exactly one queued frame, built from new data
    t_data = {16'h0050, 16'h0191};
    f1 = {line("T0=+025", "0"), line("T1=+005", "0")};
    f2 = {line("T0=+031", "0"), line("T1=+005", "0")};
    send_cmd(8'h52);
    step();
    recv("stall", f1, 0, 2);
    tx_rdy = 1'b0;
    t_data = {16'h0050, 16'h01F0};
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("stall_hold%0d", k), {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, f1[3]});
      if (k == 4 || k == 9) begin
        cmd_data = 8'h52;
        cmd_vld  = 1'b1;
      end
      step();
      cmd_vld  = 1'b0;
      cmd_data = 8'h00;
    end
    tx_rdy = 1'b1;
    recv("stall", f1, 3, f1.len() - 1);
    recv("pend", f2, 0, f2.len() - 1);
    chk("pend_alarm", 32'(alarm), 32'd1);
    cnt = 0;
    repeat (30) begin
      if (tx_vld) cnt++;
      step();
    end
    chk("pend_single", cnt, 0);
    $display("report stall: pending frame delivered, alarm %b", alarm);

    // 'G' restarts the period counter, including when already running
    t_data = {16'h0050, 16'h0191};
    fg = f1;
    send_cmd(8'h47);
    repeat (50) step();
    send_cmd(8'h47);
    n = 0;
    while (!tx_vld && n < 300) begin
      step();
      n++;
    end
    chk("go_period", n, PERIOD + 1);
    tx_rdy = 1'b0;
    send_cmd(8'h53);
    tx_rdy = 1'b1;
    recv("tick", fg, 0, fg.len() - 1);
    cnt = 0;
    repeat (3 * PERIOD + 10) begin
      if (tx_vld) cnt++;
      step();
    end
    chk("stop_quiet", cnt, 0);
    $display("report tick: first frame after %0d cycles", n);

    // Reset mid-frame abandons the frame
    send_cmd(8'h52);
    step();
    recv("rstmid", fg, 0, 2);
    rst = 1'b1;
    step();
    chk("rstmid_vld",   32'(tx_vld), 32'd0);
    chk("rstmid_busy",  32'(busy),   32'd0);
    chk("rstmid_alarm", 32'(alarm),  32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (tx_vld) cnt++;
      step();
    end
    chk("rstmid_abandon", cnt, 0);
    $display("report rstmid: frame abandoned");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
